// File: rtl/edge_frame_sequencer.sv
// Frame sequencer for the edge-detection datapath. It raster-scans pixel memory one read per
// dp_ready cycle and tags each returned pixel with x/y and 3x3 window-valid. All outputs are registered.
module edge_frame_sequencer #(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 10
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [DIM_W-1:0]  cfg_width,
    input  logic [DIM_W-1:0]  cfg_height,
    input  logic              dp_ready,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic              pix_valid,
    output logic [DIM_W-1:0]  pix_x,
    output logic [DIM_W-1:0]  pix_y,
    output logic              win_valid,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              irq
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [DIM_W-1:0]  width_q, width_d, height_q, height_d;
    logic [DIM_W-1:0]  x_q, x_d, y_q, y_d;
    logic [DIM_W-1:0]  rd_x_q, rd_x_d, rd_y_q, rd_y_d;
    logic [ADDR_W-1:0] addr_q, addr_d, rd_addr_d;
    logic              rd_en_d, busy_d, done_d, err_d, irq_d;
    logic              bad_cfg, last_col, last_row;

    // A 3x3 kernel needs at least three rows and columns to produce any window.
    assign bad_cfg  = (cfg_width < DIM_W'(3)) || (cfg_height < DIM_W'(3));
    assign last_col = (x_q == width_q - DIM_W'(1));
    assign last_row = (y_q == height_q - DIM_W'(1));

    always_comb begin
        state_d   = state_q;
        width_d   = width_q;
        height_d  = height_q;
        x_d       = x_q;
        y_d       = y_q;
        addr_d    = addr_q;
        rd_x_d    = rd_x_q;
        rd_y_d    = rd_y_q;
        rd_addr_d = mem_rd_addr;
        rd_en_d   = 1'b0;
        busy_d    = busy;
        done_d    = done;
        err_d     = err;
        irq_d     = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (cfg_start) begin
                    width_d  = cfg_width;
                    height_d = cfg_height;
                    addr_d   = cfg_base;
                    x_d      = '0;
                    y_d      = '0;
                    done_d   = 1'b0;
                    err_d    = 1'b0;
                    if (bad_cfg) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                        irq_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                busy_d = 1'b1;
                if (cfg_abort) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (dp_ready) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = addr_q;
                    rd_x_d    = x_q;
                    rd_y_d    = y_q;
                    addr_d    = addr_q + ADDR_W'(1);
                    if (last_col) begin
                        x_d = '0;
                        y_d = y_q + DIM_W'(1);
                        if (last_row) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        x_d = x_q + DIM_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (cfg_abort) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    busy_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                irq_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= IDLE;
            width_q     <= '0;
            height_q    <= '0;
            x_q         <= '0;
            y_q         <= '0;
            addr_q      <= '0;
            rd_x_q      <= '0;
            rd_y_q      <= '0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            win_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            irq         <= 1'b0;
        end else begin
            state_q     <= state_d;
            width_q     <= width_d;
            height_q    <= height_d;
            x_q         <= x_d;
            y_q         <= y_d;
            addr_q      <= addr_d;
            rd_x_q      <= rd_x_d;
            rd_y_q      <= rd_y_d;
            mem_rd_en   <= rd_en_d;
            mem_rd_addr <= rd_addr_d;
            // Pixel stage mirrors the read stage one cycle later, matching memory latency.
            pix_valid   <= mem_rd_en;
            pix_x       <= rd_x_q;
            pix_y       <= rd_y_q;
            win_valid   <= mem_rd_en && (rd_x_q >= DIM_W'(2)) && (rd_y_q >= DIM_W'(2));
            busy        <= busy_d;
            done        <= done_d;
            err         <= err_d;
            irq         <= irq_d;
        end
    end

endmodule

// File: tb/tb_edge_frame_sequencer.sv
// Randomized bench for edge_frame_sequencer: a raster-order list of expected reads per frame is
// compared against the read and pixel streams, plus frame-level timing and status checks.
module tb_edge_frame_sequencer;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        cfg_start = 1'b0;
    logic        cfg_abort = 1'b0;
    logic [15:0] cfg_base = '0;
    logic [9:0]  cfg_width = '0;
    logic [9:0]  cfg_height = '0;
    logic        dp_ready = 1'b1;
    logic        mem_rd_en, pix_valid, win_valid, busy, done, err, irq;
    logic [15:0] mem_rd_addr;
    logic [9:0]  pix_x, pix_y;

    edge_frame_sequencer #(.ADDR_W(16), .DIM_W(10)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_base(cfg_base), .cfg_width(cfg_width), .cfg_height(cfg_height),
        .dp_ready(dp_ready), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .win_valid(win_valid),
        .busy(busy), .done(done), .err(err), .irq(irq)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [15:0] addr;
        logic [9:0]  x;
        logic [9:0]  y;
    } rd_t;

    rd_t  exp_q[$];
    rd_t  pend_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   k = 0;
    int   rd_cnt, win_cnt, irq_cnt, irq_cyc, first_rd, last_pix, busy_first, busy_last;
    int   rdy_mode = 0;
    logic rdy_at_edge = 1'b0;
    logic rst_at_edge = 1'b1;
    logic prev_rd_en = 1'b0;

    task automatic check_eq(input string tag, input int got, input int expv);
        n_checks++;
        if (got == expv) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                      tag, got, got, expv, expv, cyc);
    endtask

    always @(posedge ACLK) begin
        rdy_at_edge <= dp_ready;
        rst_at_edge <= ARESET;
        cyc         <= cyc + 1;
    end

    initial forever begin
        @(posedge ACLK);
        #1;
        case (rdy_mode)
            0:       dp_ready = 1'b1;
            1:       dp_ready = ~dp_ready;
            default: dp_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Stream monitor: reads must follow the raster list, pixels follow reads by one cycle.
    always @(negedge ACLK) begin : mon
        rd_t e;
        if (rst_at_edge) begin
            prev_rd_en = 1'b0;
            pend_q.delete();
        end else begin
            check_eq("pix_follows_rd", int'(pix_valid), int'(prev_rd_en));
            if (pix_valid) begin
                check_eq("pix_pending", pend_q.size(), 1);
                if (pend_q.size() != 0) begin
                    e = pend_q.pop_front();
                    check_eq("pix_x", int'(pix_x), int'(e.x));
                    check_eq("pix_y", int'(pix_y), int'(e.y));
                    check_eq("win_valid", int'(win_valid), int'(e.x >= 2 && e.y >= 2));
                end
                last_pix = cyc;
            end else begin
                check_eq("win_idle", int'(win_valid), 0);
            end
            if (mem_rd_en) begin
                check_eq("rd_gated", int'(rdy_at_edge), 1);
                check_eq("rd_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("rd_addr", int'(mem_rd_addr), int'(e.addr));
                    pend_q.push_back(e);
                end
                if (first_rd < 0) first_rd = cyc;
                rd_cnt++;
            end
            if (win_valid) win_cnt++;
            if (busy) begin
                if (busy_first < 0) busy_first = cyc;
                busy_last = cyc;
            end
            if (irq) begin
                check_eq("irq_with_done", int'(done), 1);
                irq_cnt++;
                irq_cyc = cyc;
            end
            prev_rd_en = mem_rd_en;
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic start_frame(input int b, input int w, input int h, input int mode,
                               input bit with_abort);
        exp_q.delete();
        if (w >= 3 && h >= 3)
            for (int y = 0; y < h; y++)
                for (int x = 0; x < w; x++)
                    exp_q.push_back('{addr: 16'(b + y * w + x), x: 10'(x), y: 10'(y)});
        rd_cnt = 0; win_cnt = 0; irq_cnt = 0; irq_cyc = -1;
        first_rd = -1; last_pix = -1; busy_first = -1; busy_last = -1;
        rdy_mode   = mode;
        cfg_base   = 16'(b);
        cfg_width  = 10'(w);
        cfg_height = 10'(h);
        cfg_start  = 1'b1;
        cfg_abort  = with_abort;
        k = cyc + 1;
        tick();
        cfg_start  = 1'b0;
        cfg_abort  = 1'b0;
        cfg_base   = 16'($urandom);
        cfg_width  = 10'($urandom_range(0, 2));
        cfg_height = 10'($urandom_range(0, 2));
        check_eq("busy_at_start", int'(busy), 0);
        if (w >= 3 && h >= 3) check_eq("done_cleared", int'(done), 0);
    endtask

    task automatic finish_frame(input int w, input int h, input bit timed);
        int  n = 0;
        bit  good = (w >= 3 && h >= 3);
        while (irq_cnt == 0 && n < 3000) begin
            tick();
            n++;
        end
        check_eq("irq_seen", int'(irq_cnt != 0), 1);
        repeat (4) tick();
        check_eq("irq_once", irq_cnt, 1);
        check_eq("done", int'(done), 1);
        check_eq("err", int'(err), int'(!good));
        check_eq("busy_end", int'(busy), 0);
        check_eq("reads_left", exp_q.size(), 0);
        check_eq("read_count", rd_cnt, good ? w * h : 0);
        check_eq("win_count", win_cnt, good ? (w - 2) * (h - 2) : 0);
        if (good) begin
            check_eq("busy_first", busy_first, k + 1);
            check_eq("busy_last", busy_last, irq_cyc - 1);
            check_eq("irq_after_pix", irq_cyc, last_pix + 1);
            if (timed) begin
                check_eq("first_rd", first_rd, k + 1);
                check_eq("irq_cycle", irq_cyc, k + w * h + 2);
            end
        end else begin
            check_eq("irq_cycle_err", irq_cyc, k);
            check_eq("busy_never", busy_first, -1);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_rd_en"}, int'(mem_rd_en), 0);
        check_eq({tag, "_rd_addr"}, int'(mem_rd_addr), 0);
        check_eq({tag, "_pix_valid"}, int'(pix_valid), 0);
        check_eq({tag, "_pix_xy"}, int'({pix_x, pix_y}), 0);
        check_eq({tag, "_win"}, int'(win_valid), 0);
        check_eq({tag, "_status"}, int'({busy, done, err, irq}), 0);
    endtask

    initial begin
        int n;
        int w, h, mode;
        ARESET = 1'b1;
        repeat (3) tick();
        check_outputs_zero("reset");
        ARESET = 1'b0;
        tick();

        // 4x3 frame, continuous and alternating ready.
        start_frame(16'h0100, 4, 3, 0, 1'b0);
        finish_frame(4, 3, 1'b1);
        start_frame(16'h0100, 4, 3, 1, 1'b0);
        finish_frame(4, 3, 1'b0);

        // Too narrow: error completion without reads.
        start_frame(16'h0200, 2, 5, 0, 1'b0);
        finish_frame(2, 5, 1'b0);

        // Address wraps past the top of memory.
        start_frame(16'hFFFE, 3, 3, 0, 1'b0);
        finish_frame(3, 3, 1'b1);

        // Start re-pulsed mid-frame must not disturb the frame in progress.
        start_frame(16'h1234, 8, 8, 0, 1'b0);
        repeat (20) tick();
        cfg_base = 16'h4000; cfg_width = 10'd3; cfg_height = 10'd3; cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        finish_frame(8, 8, 1'b1);

        // Abort after the 10th read.
        start_frame(16'h0800, 8, 8, 0, 1'b0);
        n = 0;
        while (rd_cnt < 10 && n < 300) begin
            @(negedge ACLK);
            #1;
            n++;
        end
        check_eq("abort_reach", rd_cnt, 10);
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        exp_q.delete();
        check_eq("abort_rd_en", int'(mem_rd_en), 0);
        check_eq("abort_busy", int'(busy), 0);
        repeat (10) tick();
        check_eq("abort_reads", rd_cnt, 10);
        check_eq("abort_no_irq", irq_cnt, 0);
        check_eq("abort_status", int'({busy, done, err}), 0);
        check_eq("abort_pend", pend_q.size(), 0);
        start_frame(16'h0040, 3, 3, 0, 1'b1);
        finish_frame(3, 3, 1'b1);

        // Reset in the middle of a frame.
        start_frame(16'h0300, 6, 5, 2, 1'b0);
        repeat (8) tick();
        ARESET = 1'b1;
        tick();
        exp_q.delete();
        check_outputs_zero("midrst");
        tick();
        ARESET = 1'b0;
        repeat (5) tick();
        check_eq("midrst_no_irq", irq_cnt, 0);
        check_eq("midrst_idle", int'({mem_rd_en, busy, done}), 0);

        // Random frames, some with illegal dimensions.
        for (int i = 0; i < 10; i++) begin
            w    = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 2) : $urandom_range(3, 9);
            h    = $urandom_range(3, 6);
            mode = $urandom_range(0, 2);
            start_frame(int'($urandom_range(0, 65535)), w, h, mode, 1'b0);
            finish_frame(w, h, mode == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
